// File: rtl/rename_map_table.sv
// Register-rename map table: speculative and retirement AR->PR maps, per-PR ready bits,
// and the allocate/free/rollback handshake with the physical-register free list.
module rename_map_table #(
  parameter int ARCH_REG_SZ = 32,
  parameter int PHYS_REG_SZ = 64,
  parameter int AR_W        = 5,
  parameter int PR_W        = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rename_en,
  input  logic                   rename_has_dest,
  input  logic [AR_W-1:0]        rename_dest_ar,
  input  logic [AR_W-1:0]        rename_src1_ar,
  input  logic [AR_W-1:0]        rename_src2_ar,
  output logic                   rename_stall,
  output logic [PR_W-1:0]        src1_pr,
  output logic [PR_W-1:0]        src2_pr,
  output logic                   src1_ready,
  output logic                   src2_ready,
  output logic [PR_W-1:0]        dest_pr,
  output logic [PR_W-1:0]        old_dest_pr,
  input  logic                   cdb_valid,
  input  logic [PR_W-1:0]        cdb_pr,
  input  logic                   commit_en,
  input  logic [AR_W-1:0]        commit_ar,
  input  logic [PR_W-1:0]        commit_pr,
  input  logic                   rollback,
  input  logic                   fl_is_empty,
  input  logic [PR_W-1:0]        fl_dequeue_pr,
  output logic                   fl_dequeue_en,
  output logic                   fl_enqueue_en,
  output logic [PR_W-1:0]        fl_enqueue_pr,
  output logic                   fl_rollback,
  output logic [PHYS_REG_SZ-1:0] fl_rollback_mask
);

  logic [PR_W-1:0]        r_spec_map [ARCH_REG_SZ];
  logic [PR_W-1:0]        r_arch_map [ARCH_REG_SZ];
  logic [PHYS_REG_SZ-1:0] r_ready;

  logic [PR_W-1:0]        w_next_arch [ARCH_REG_SZ];
  logic [PHYS_REG_SZ-1:0] w_present;
  logic                   w_need_dest;
  logic                   w_commit_ok;
  logic [PR_W-1:0]        w_src1_pr;
  logic [PR_W-1:0]        w_src2_pr;

  assign w_need_dest = rename_en && rename_has_dest && (rename_dest_ar != '0);
  assign w_commit_ok = commit_en && (commit_ar != '0);

  always_comb begin
    w_src1_pr     = (rename_src1_ar == '0) ? '0 : r_spec_map[rename_src1_ar];
    w_src2_pr     = (rename_src2_ar == '0) ? '0 : r_spec_map[rename_src2_ar];
    src1_pr       = w_src1_pr;
    src2_pr       = w_src2_pr;
    src1_ready    = r_ready[w_src1_pr] || (cdb_valid && (cdb_pr == w_src1_pr));
    src2_ready    = r_ready[w_src2_pr] || (cdb_valid && (cdb_pr == w_src2_pr));
    dest_pr       = fl_dequeue_pr;
    old_dest_pr   = r_spec_map[rename_dest_ar];
    fl_enqueue_pr = r_arch_map[commit_ar];
    fl_enqueue_en = w_commit_ok && (r_arch_map[commit_ar] != '0);
    // an empty free list is tolerated when this cycle's commit frees a PR it can pass through
    rename_stall  = rollback || (w_need_dest && fl_is_empty && !fl_enqueue_en);
    fl_dequeue_en = w_need_dest && !rename_stall;
    fl_rollback   = rollback;
  end

  always_comb begin
    for (int unsigned a = 0; a < ARCH_REG_SZ; a++) w_next_arch[a] = r_arch_map[a];
    if (w_commit_ok) w_next_arch[commit_ar] = commit_pr;
    w_present = '0;
    for (int unsigned a = 0; a < ARCH_REG_SZ; a++) w_present[w_next_arch[a]] = 1'b1;
    fl_rollback_mask    = ~w_present;
    fl_rollback_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned a = 0; a < ARCH_REG_SZ; a++) begin
        r_spec_map[a] <= '0;
        r_arch_map[a] <= '0;
      end
      r_ready <= '1;
    end else begin
      for (int unsigned a = 0; a < ARCH_REG_SZ; a++) r_arch_map[a] <= w_next_arch[a];
      if (rollback) begin
        for (int unsigned a = 0; a < ARCH_REG_SZ; a++) r_spec_map[a] <= w_next_arch[a];
        r_ready <= '1;
      end else begin
        if (cdb_valid) r_ready[cdb_pr] <= 1'b1;
        // allocation clear is issued last so it beats a same-cycle broadcast on the same PR
        if (fl_dequeue_en) begin
          r_spec_map[rename_dest_ar] <= fl_dequeue_pr;
          r_ready[fl_dequeue_pr]     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: hand-computed vectors checked with immediate assertions.
module tb_rename_map_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        rename_en, rename_has_dest;
  logic [4:0]  rename_dest_ar, rename_src1_ar, rename_src2_ar;
  logic        rename_stall;
  logic [5:0]  src1_pr, src2_pr, dest_pr, old_dest_pr;
  logic        src1_ready, src2_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_pr;
  logic        commit_en;
  logic [4:0]  commit_ar;
  logic [5:0]  commit_pr;
  logic        rollback, fl_is_empty;
  logic [5:0]  fl_dequeue_pr;
  logic        fl_dequeue_en, fl_enqueue_en, fl_rollback;
  logic [5:0]  fl_enqueue_pr;
  logic [63:0] fl_rollback_mask;

  int n_vec  = 0;
  int n_fail = 0;

  rename_map_table #(.ARCH_REG_SZ(32), .PHYS_REG_SZ(64), .AR_W(5), .PR_W(6)) dut (
    .clk(clk), .reset(reset),
    .rename_en(rename_en), .rename_has_dest(rename_has_dest),
    .rename_dest_ar(rename_dest_ar), .rename_src1_ar(rename_src1_ar), .rename_src2_ar(rename_src2_ar),
    .rename_stall(rename_stall), .src1_pr(src1_pr), .src2_pr(src2_pr),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .dest_pr(dest_pr), .old_dest_pr(old_dest_pr),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
    .commit_en(commit_en), .commit_ar(commit_ar), .commit_pr(commit_pr),
    .rollback(rollback), .fl_is_empty(fl_is_empty), .fl_dequeue_pr(fl_dequeue_pr),
    .fl_dequeue_en(fl_dequeue_en), .fl_enqueue_en(fl_enqueue_en), .fl_enqueue_pr(fl_enqueue_pr),
    .fl_rollback(fl_rollback), .fl_rollback_mask(fl_rollback_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rename_en = 0; rename_has_dest = 0; rename_dest_ar = 0;
    rename_src1_ar = 0; rename_src2_ar = 0;
    cdb_valid = 0; cdb_pr = 0; commit_en = 0; commit_ar = 0; commit_pr = 0;
    rollback = 0; fl_is_empty = 0; fl_dequeue_pr = 0;
  endtask

  task automatic ren(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [5:0] fpr);
    rename_en = 1; rename_has_dest = 1; rename_dest_ar = d;
    rename_src1_ar = s1; rename_src2_ar = s2; fl_dequeue_pr = fpr;
  endtask

  task automatic cmt(input logic [4:0] a, input logic [5:0] p);
    commit_en = 1; commit_ar = a; commit_pr = p;
  endtask

  // inputs change at negedge; outputs checked 1 time unit later, well clear of posedge
  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    rename_src1_ar = 3; rename_src2_ar = 4;
    #1;
    chk("rst_src1_pr", src1_pr, 0);
    chk("rst_src2_pr", src2_pr, 0);
    chk("rst_src1_rdy", src1_ready, 1);
    chk("rst_src2_rdy", src2_ready, 1);
    chk("rst_deq_en", fl_dequeue_en, 0);
    chk("rst_stall", rename_stall, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    // first rename: dest 5 <- PR1
    nxt(); ren(5, 3, 4, 1); #1;
    chk("r1_src1_pr", src1_pr, 0);
    chk("r1_src2_pr", src2_pr, 0);
    chk("r1_src1_rdy", src1_ready, 1);
    chk("r1_src2_rdy", src2_ready, 1);
    chk("r1_dest_pr", dest_pr, 1);
    chk("r1_old_dest", old_dest_pr, 0);
    chk("r1_deq_en", fl_dequeue_en, 1);
    chk("r1_stall", rename_stall, 0);
    nxt(); rename_src1_ar = 5; #1;
    chk("r1_next_src1_pr", src1_pr, 1);
    chk("r1_next_src1_rdy", src1_ready, 0);

    // re-rename dest 5 <- PR2; source 5 still sees PR1
    nxt(); ren(5, 5, 0, 2); #1;
    chk("r2_old_dest", old_dest_pr, 1);
    chk("r2_src1_pre", src1_pr, 1);
    nxt(); cmt(5, 1); #1;
    chk("c1_enq_en", fl_enqueue_en, 0);
    nxt(); cmt(5, 2); #1;
    chk("c2_enq_en", fl_enqueue_en, 1);
    chk("c2_enq_pr", fl_enqueue_pr, 1);

    // CDB bypass: dest 8 <- PR3 then broadcast PR3 while reading AR8
    nxt(); ren(8, 0, 0, 3);
    nxt(); rename_src1_ar = 8; rename_src2_ar = 5; cdb_valid = 1; cdb_pr = 3; #1;
    chk("byp_src1_pr", src1_pr, 3);
    chk("byp_src1_rdy", src1_ready, 1);
    chk("byp_src2_rdy", src2_ready, 0);
    nxt(); rename_src1_ar = 8; #1;
    chk("byp_after_rdy", src1_ready, 1);

    // allocation clear beats same-cycle CDB set on the same PR
    nxt(); ren(9, 0, 0, 4); cdb_valid = 1; cdb_pr = 4;
    nxt(); rename_src1_ar = 9; #1;
    chk("clr_wins_pr", src1_pr, 4);
    chk("clr_wins_rdy", src1_ready, 0);

    // empty free list, no commit -> stall
    nxt(); ren(7, 0, 0, 5); fl_is_empty = 1; #1;
    chk("empty_stall", rename_stall, 1);
    chk("empty_deq_en", fl_dequeue_en, 0);
    nxt(); rename_src1_ar = 7; #1;
    chk("empty_map_kept", src1_pr, 0);
    // empty but commit frees PR2 (arch5=2) which the free list passes through
    nxt(); ren(7, 0, 0, 2); fl_is_empty = 1; cmt(5, 6); #1;
    chk("pass_stall", rename_stall, 0);
    chk("pass_deq_en", fl_dequeue_en, 1);
    chk("pass_enq_pr", fl_enqueue_pr, 2);
    chk("pass_dest_pr", dest_pr, 2);
    // AR0 destination never needs a PR
    nxt(); ren(0, 0, 0, 5); fl_is_empty = 1; #1;
    chk("ar0_stall", rename_stall, 0);
    chk("ar0_deq_en", fl_dequeue_en, 0);

    // rollback with AR6->PR4 speculative, commit AR5->PR3 same cycle
    nxt(); ren(6, 0, 0, 4);
    nxt(); ren(10, 0, 0, 11); rollback = 1; cmt(5, 3); #1;
    chk("rb_stall", rename_stall, 1);
    chk("rb_deq_en", fl_dequeue_en, 0);
    chk("rb_flag", fl_rollback, 1);
    chk("rb_enq_pr", fl_enqueue_pr, 6);
    chk("rb_mask", fl_rollback_mask, 64'hFFFF_FFFF_FFFF_FFF6);
    nxt(); rename_src1_ar = 6; rename_src2_ar = 5; #1;
    chk("rb_src6_pr", src1_pr, 0);
    chk("rb_src6_rdy", src1_ready, 1);
    chk("rb_src5_pr", src2_pr, 3);
    chk("rb_src5_rdy", src2_ready, 1);
    nxt(); rename_src1_ar = 10; rename_src2_ar = 8; #1;
    chk("rb_src10_pr", src1_pr, 0);
    chk("rb_src8_pr", src2_pr, 0);

    // asynchronous reset mid-sequence
    nxt(); ren(11, 0, 0, 7); cmt(11, 7);
    nxt(); rename_src1_ar = 11; rename_src2_ar = 5; #1;
    chk("pre_rst_src11", src1_pr, 7);
    chk("pre_rst_src11_rdy", src1_ready, 0);
    nxt(); rename_src1_ar = 11; rename_src2_ar = 5; cmt(11, 12); reset = 1; #1;
    chk("mid_rst_src1", src1_pr, 0);
    chk("mid_rst_src2", src2_pr, 0);
    chk("mid_rst_rdy", src1_ready, 1);
    chk("mid_rst_enq", fl_enqueue_en, 0);
    @(negedge clk); reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Register-rename stage that sits directly upstream of the physical-register free list, and also feeds it.
- Holds the speculative map (AR->PR) and the retirement map (AR->PR), plus per-PR ready bits.
- Allocates destination PRs by dequeuing from the free list.
- Returns PRs to the free list on commit (enqueue) and on mispredict (rollback mask).

Parameters:
- ARCH_REG_SZ, 32, number of architectural registers; AR 0 is hardwired zero.
- PHYS_REG_SZ, 64, number of physical registers; PR 0 is the permanent zero/initial register.
- AR_W, 5, AR index width.
- PR_W, 6, PR index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rename_en  in  1  valid instruction to rename this cycle
- rename_has_dest  in  1  instruction writes a register
- rename_dest_ar  in  AR_W  destination AR
- rename_src1_ar  in  AR_W  source 1 AR
- rename_src2_ar  in  AR_W  source 2 AR
- rename_stall  out  1  rename not accepted this cycle
- src1_pr  out  PR_W  PR for source 1
- src2_pr  out  PR_W  PR for source 2
- src1_ready  out  1  source 1 value is available
- src2_ready  out  1  source 2 value is available
- dest_pr  out  PR_W  newly allocated PR
- old_dest_pr  out  PR_W  previous speculative mapping of the destination, for the ROB
- cdb_valid  in  1  completion broadcast
- cdb_pr  in  PR_W  completing PR
- commit_en  in  1  retire one instruction with a destination
- commit_ar  in  AR_W  retiring destination AR
- commit_pr  in  PR_W  retiring destination PR
- rollback  in  1  mispredict recovery
- fl_is_empty  in  1  from free list
- fl_dequeue_pr  in  PR_W  from free list
- fl_dequeue_en  out  1  to free list
- fl_enqueue_en  out  1  to free list
- fl_enqueue_pr  out  PR_W  to free list
- fl_rollback  out  1  to free list
- fl_rollback_mask  out  PHYS_REG_SZ  to free list

Behaviour:
- Reset (asynchronous, immediate):
  - All spec_map and arch_map entries = 0.
  - All ready bits = 1.
  - Outputs then take their combinational values from this state: src PRs 0, src ready 1, fl_dequeue_en 0.
- Renaming is combinational in the same cycle; state updates at the next posedge clk.
- need_dest = rename_en && rename_has_dest && rename_dest_ar != 0.
- rename_stall = rollback || (need_dest && fl_is_empty && !fl_enqueue_en).
  - Enqueue during an empty cycle is passed through by the free list.
- fl_dequeue_en = need_dest && !rename_stall.
- dest_pr = fl_dequeue_pr.
- old_dest_pr = spec_map[rename_dest_ar].
- Source lookup:
  - srcN_pr = spec_map[srcN_ar], using the pre-update map, so a source equal to this instruction's destination AR sees the old PR.
  - AR 0 always yields PR 0.
  - srcN_ready = ready[srcN_pr] || (cdb_valid && cdb_pr == srcN_pr).
- Accepted rename with a destination: at the next edge, spec_map[dest_ar] <= dest_pr and ready[dest_pr] <= 0.
  - This clear wins over a same-cycle CDB set on the same PR.
- CDB: ready[cdb_pr] <= 1, subject to the rule above.
- Commit (commit_en):
  - arch_map[commit_ar] <= commit_pr.
  - fl_enqueue_en = commit_en && arch_map[commit_ar] != 0 && commit_ar != 0.
  - fl_enqueue_pr = arch_map[commit_ar] (the old retirement PR).
  - PR 0 is never freed.
- Rollback (one cycle):
  - next_arch = arch_map with the same-cycle commit applied.
  - spec_map <= next_arch.
  - All ready bits <= 1.
  - fl_rollback = rollback.
  - fl_rollback_mask[p] = 1 for every p != 0 not present in next_arch; bit 0 = 0.
  - Rename is refused that cycle: rename_stall = 1, fl_dequeue_en = 0.
  - fl_enqueue_en may still assert; the free list ignores it, and the mask already covers the PR.
- At most one rename and one commit per cycle.
- commit_ar == rename_dest_ar in the same cycle is legal: each map updates independently.

Test Plan:
- Reset, then rename src1=3 src2=4 dest=5 with fl_dequeue_pr=1 -> src PRs 0/0 ready 1, dest_pr=1, old_dest_pr=0, fl_dequeue_en=1. Next cycle, src1=5 yields PR 1 with ready 0.
- Rename dest=5 (PR 1), then dest=5 again with fl_dequeue_pr=2 -> old_dest_pr=1. Commit (5,1) -> no enqueue (old arch PR 0). Commit (5,2) -> fl_enqueue_en=1, fl_enqueue_pr=1.
- PR 1 allocated with ready 0; same cycle cdb_valid cdb_pr=1 and rename src1=5 -> src1_ready=1 (bypass); ready[1]=1 the next cycle.
- fl_is_empty=1, no commit, rename dest=7 -> rename_stall=1, fl_dequeue_en=0, map unchanged. Repeat with a commit enqueuing PR 9 -> no stall, dest_pr=9.
- Map AR5->PR3 and AR6->PR4 speculatively, with arch AR5->PR3 committed the same cycle as rollback -> fl_rollback_mask has bit 4 set and bits 0 and 3 clear. Next cycle src 6 -> PR 0 ready 1, src 5 -> PR 3.
- Assert reset mid-sequence with maps non-zero -> maps cleared without a clock edge; src PRs read 0 immediately.
